// File: rtl/key_svc_pkg.sv
// Shared types for the key PIO service: FSM state encoding and the PIO register map.
package key_svc_pkg;

  typedef enum logic [2:0] {
    INIT_MASK,
    IDLE,
    RD_EDGE,
    CAP_EDGE,
    CLR_EDGE,
    PUSH
  } key_state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for key events; zero read latency (head is always on data_o).
module key_evt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/key_pio_service.sv
// Avalon-MM master servicing the 4-bit key PIO and queueing captured key presses.
// Optional KEY_SVC_TIMESTAMP_EN adds a free-running timestamp stored with each event.
module key_pio_service
  import key_svc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       cfg_mask,
  input  logic             cfg_load,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [3:0]       m_writedata,
  input  logic [3:0]       m_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_keys,
`ifdef KEY_SVC_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic             overflow,
  output logic             busy,
  output key_state_e       dbg_state
);

`ifdef KEY_SVC_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int ENTRY_W = 4 + TS_EN * TS_W;

  key_state_e         state_q, state_d;
  logic               pend_q, pend_d;
  logic [3:0]         cap_keys_q, cap_keys_d;
  logic               ovf_q, ovf_d;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT_MASK;
      pend_q     <= 1'b0;
      cap_keys_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cap_keys_q <= cap_keys_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | cfg_load;
    cap_keys_d = cap_keys_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;
    unique case (state_q)
      INIT_MASK: state_d = IDLE;
      IDLE: begin
        // A fresh or pending mask reload is served before any interrupt.
        pend_d = 1'b0;
        if (cfg_load || pend_q) begin
          state_d = INIT_MASK;
        end else if (pio_irq) begin
          state_d = RD_EDGE;
        end
      end
      RD_EDGE: state_d = CAP_EDGE;
      CAP_EDGE: begin
        cap_keys_d = m_readdata;
        state_d    = CLR_EDGE;
      end
      CLR_EDGE: state_d = (|cap_keys_q) ? PUSH : IDLE;
      PUSH: begin
        if (fifo_full) begin
          ovf_d = 1'b1;
        end else begin
          fifo_push = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = INIT_MASK;
    endcase
  end

  // Bus is quiet while reset is held even though the state register sits in INIT_MASK.
  always_comb begin
    m_address    = ADDR_DATA;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    if (reset_n) begin
      unique case (state_q)
        INIT_MASK: begin
          m_address    = ADDR_MASK;
          m_chipselect = 1'b1;
          m_write_n    = 1'b0;
          m_writedata  = cfg_mask;
        end
        RD_EDGE, CAP_EDGE: begin
          m_address    = ADDR_EDGE;
          m_chipselect = 1'b1;
        end
        CLR_EDGE: begin
          m_address    = ADDR_EDGE;
          m_chipselect = 1'b1;
          m_write_n    = 1'b0;
          m_writedata  = 4'hF;
        end
        default: ;
      endcase
    end
  end

`ifdef KEY_SVC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] cap_ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q     <= '0;
      cap_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (state_q == CAP_EDGE) begin
        cap_ts_q <= ts_q;
      end
    end
  end

  assign fifo_din = {cap_keys_q, cap_ts_q};
  assign evt_keys = fifo_dout[ENTRY_W-1 -: 4];
  assign evt_ts   = fifo_dout[TS_W-1:0];
`else
  assign fifo_din = cap_keys_q;
  assign evt_keys = fifo_dout;
`endif

  key_evt_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (evt_ready),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_key_pio_service.sv
// Bench for key_pio_service: behavioural key PIO, event scoreboard and directed/random presses.
module tb_key_pio_service;
  import key_svc_pkg::*;

  localparam int DEPTH = 4;
  localparam int TS_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [3:0]       cfg_mask;
  logic             cfg_load;
  logic [1:0]       m_address;
  logic             m_chipselect;
  logic             m_write_n;
  logic [3:0]       m_writedata;
  logic [3:0]       m_readdata;
  logic             pio_irq;
  logic             evt_valid;
  logic             evt_ready;
  logic [3:0]       evt_keys;
`ifdef KEY_SVC_TIMESTAMP_EN
  logic [TS_W-1:0]  evt_ts;
`endif
  logic             overflow;
  logic             busy;
  key_state_e       dbg_state;

  key_pio_service #(.FIFO_DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_mask     (cfg_mask),
    .cfg_load     (cfg_load),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .pio_irq      (pio_irq),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_keys     (evt_keys),
`ifdef KEY_SVC_TIMESTAMP_EN
    .evt_ts       (evt_ts),
`endif
    .overflow     (overflow),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // behavioural key PIO (not reset by reset_n) plus bus activity counters
  logic [3:0] in_port  = 4'hF;
  logic [3:0] in_prev  = 4'hF;
  logic [3:0] edge_cap = 4'h0;
  logic [3:0] pio_mask = 4'h0;
  logic [3:0] rdata_q  = 4'h0;
  logic       rd_prev  = 1'b0;
  logic       rd_now;
  int         mask_wr_cnt = 0;
  int         edge_rd_cnt = 0;
  int         edge_clr_cnt = 0;
  logic [3:0] last_mask = 4'h0;

  assign rd_now     = m_chipselect && m_write_n && (m_address == 2'd3);
  assign m_readdata = rdata_q;
  assign pio_irq    = |(edge_cap & pio_mask);

  always @(posedge clk) begin
    in_prev <= in_port;
    if (m_chipselect && !m_write_n && m_address == 2'd3) begin
      edge_cap     <= 4'h0;
      edge_clr_cnt <= edge_clr_cnt + 1;
    end else begin
      edge_cap <= edge_cap | (in_prev & ~in_port);
    end
    if (m_chipselect && !m_write_n && m_address == 2'd2) begin
      pio_mask    <= m_writedata;
      last_mask   <= m_writedata;
      mask_wr_cnt <= mask_wr_cnt + 1;
    end
    if (rd_now && !rd_prev) edge_rd_cnt <= edge_rd_cnt + 1;
    rd_prev <= rd_now;
    case (m_address)
      2'd0:    rdata_q <= in_port;
      2'd2:    rdata_q <= pio_mask;
      2'd3:    rdata_q <= edge_cap;
      default: rdata_q <= 4'h0;
    endcase
  end

  // scoreboard and reference model
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];
  logic       exp_ovf;
  logic [3:0] cur_mask;
  logic [3:0] cap_pending;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_event(input logic [3:0] keys);
    if (exp_q.size() < DEPTH) exp_q.push_back(keys);
    else exp_ovf = 1'b1;
  endtask

  // Captured bits accumulate in the PIO; once any of them is unmasked the whole set is read out.
  task automatic model_capture(input logic [3:0] keys);
    cap_pending = cap_pending | keys;
    if (|(cap_pending & cur_mask)) begin
      expect_event(cap_pending);
      cap_pending = 4'h0;
    end
  endtask

  // driver tasks
  task automatic press(input logic [3:0] keys);
    @(negedge clk);
    in_port = in_port & ~keys;
    model_capture(keys);
    repeat (8) @(negedge clk);
    in_port = in_port | keys;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_mask(input logic [3:0] m);
    @(negedge clk);
    cfg_mask = m;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    cur_mask = m;
    model_capture(4'h0);
    repeat (10) @(negedge clk);
    chk("mask_reg", last_mask, m);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      @(negedge clk);
      if (!evt_valid) break;
      if (exp_q.size() > 0) chk({tag, "_keys"}, evt_keys, exp_q.pop_front());
      else chk({tag, "_extra_evt"}, evt_valid, 1'b0);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  int rd0, clr0, m0;

  initial begin
    reset_n     = 1'b0;
    cfg_mask    = 4'hF;
    cfg_load    = 1'b0;
    evt_ready   = 1'b0;
    cur_mask    = 4'hF;
    cap_pending = 4'h0;
    exp_ovf     = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_addr", m_address, 2'd0);
    chk("rst_cs", m_chipselect, 1'b0);
    chk("rst_wn", m_write_n, 1'b1);
    chk("rst_wd", m_writedata, 4'h0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_keys", evt_keys, 4'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_state", 32'(dbg_state), 32'(INIT_MASK));
`ifdef KEY_SVC_TIMESTAMP_EN
    chk("rst_ts", evt_ts, '0);
`endif

    // mask write on the first edge after release
    reset_n = 1'b1;
    #1;
    chk("init_cs", m_chipselect, 1'b1);
    chk("init_wn", m_write_n, 1'b0);
    chk("init_addr", m_address, 2'd2);
    chk("init_wd", m_writedata, 4'hF);
    @(negedge clk);
    chk("init_idle", busy, 1'b0);
    chk("init_cnt", mask_wr_cnt, 1);
    chk("init_mask", last_mask, 4'hF);
    repeat (2) @(negedge clk);

    // key 2 press with exact latency
    rd0  = edge_rd_cnt;
    clr0 = edge_clr_cnt;
    in_port[2] = 1'b0;
    expect_event(4'h4);
    repeat (5) @(negedge clk);
    chk("k2_early", evt_valid, 1'b0);
    @(negedge clk);
    chk("k2_valid", evt_valid, 1'b1);
    chk("k2_keys", evt_keys, 4'h4);
    chk("k2_reads", edge_rd_cnt - rd0, 1);
    chk("k2_clears", edge_clr_cnt - clr0, 1);
    in_port[2] = 1'b1;
    drain("k2");

    // overflow with consumer stalled
    for (int i = 0; i < DEPTH + 1; i++) press(4'($urandom_range(1, 15)));
    chk("ovf_flag", overflow, exp_ovf);
    chk("ovf_valid", evt_valid, 1'b1);
    chk("ovf_head", evt_keys, exp_q[0]);
    drain("ovf");

    // cfg_load during CAP_EDGE is deferred to the next IDLE
    @(negedge clk);
    in_port[0] = 1'b0;
    model_capture(4'h1);
    repeat (3) @(negedge clk);
    cfg_mask = 4'h1;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("pend_cs", m_chipselect, 1'b1);
    chk("pend_wn", m_write_n, 1'b0);
    chk("pend_addr", m_address, 2'd2);
    chk("pend_wd", m_writedata, 4'h1);
    cur_mask = 4'h1;
    in_port[0] = 1'b1;
    repeat (4) @(negedge clk);
    drain("pend");

    // masked key 3 produces nothing until unmasked
    rd0 = edge_rd_cnt;
    press(4'h8);
    chk("mask3_reads", edge_rd_cnt - rd0, 0);
    chk("mask3_valid", evt_valid, 1'b0);
    load_mask(4'hF);
    drain("unmask3");

    // two keys in the same cycle
    press(4'h3);
    drain("k01");

    // random masks and presses
    load_mask(4'($urandom_range(1, 15)));
    for (int i = 0; i < 10; i++) begin
      press(4'($urandom_range(1, 15)));
      if ($urandom_range(0, 2) == 0) drain("rnd");
    end
    load_mask(4'hF);
    drain("rnd_end");
    chk("rnd_ovf", overflow, exp_ovf);

    // reset asserted in PUSH; a key captured meanwhile is serviced after init
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (5) @(negedge clk);
    reset_n    = 1'b0;
    in_port[2] = 1'b0;
    #1;
    chk("mid_valid", evt_valid, 1'b0);
    chk("mid_ovf", overflow, 1'b0);
    chk("mid_busy", busy, 1'b1);
    exp_q.delete();
    exp_ovf = 1'b0;
    m0 = mask_wr_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_event(4'h4);
    repeat (12) @(negedge clk);
    chk("mid_mask_wr", mask_wr_cnt - m0, 1);
    in_port = 4'hF;
    drain("mid");
    chk("mid_ovf_end", overflow, exp_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
